// File: rtl/sub16_seq_if.sv
// Operand/result handshake bundle for sub16_seq.
// The ovf signal exists only when SUB16_OVF_EN is defined.
interface sub16_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB16_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SUB16_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SUB16_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/sub16_seq.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB first.
// Define SUB16_OVF_EN to add the signed-overflow output. Requires DIGIT < WIDTH.
module sub16_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sub16_seq_if.slave  bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic [DIGIT:0]     w_slice;
  logic               w_last;
`ifdef SUB16_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  // Top bit of the (DIGIT+1)-bit difference is the borrow out of the slice.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] a_d,
                                               input logic [DIGIT-1:0] b_d,
                                               input logic             bi);
    return {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, bi};
  endfunction

  assign w_slice = sub_digit(r_a[DIGIT-1:0], r_b[DIGIT-1:0], r_borrow);
  assign w_last  = (r_cnt == CNT_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands shift right one digit per RUN cycle; each slice enters diff at the top,
  // so after NDIG cycles diff holds the full result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SUB16_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
`ifdef SUB16_OVF_EN
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_diff   <= {w_slice[DIGIT-1:0], r_diff[WIDTH-1:DIGIT]};
          r_borrow <= w_slice[DIGIT];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout <= w_slice[DIGIT];
`ifdef SUB16_OVF_EN
            r_ovf  <= (r_a_msb != r_b_msb) && (w_slice[DIGIT-1] != r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SUB16_OVF_EN
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_sub16_seq.sv
// Directed bench for sub16_seq: reset, arithmetic vectors, latency, back-pressure, mid-run reset.
module tb_sub16_seq;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  sub16_seq_if #(.WIDTH(16)) ifc ();

  sub16_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic rdy);
    @(negedge clk);
    check("in_ready_idle", 32'(ifc.in_ready), 32'd1);
    ifc.a         = a;
    ifc.b         = b;
    ifc.bin       = bi;
    ifc.in_valid  = 1'b1;
    ifc.out_ready = rdy;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.a        = 16'($urandom);
    ifc.b        = 16'($urandom);
    ifc.bin      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ifc.out_valid) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic eo);
    check({tag, "_diff"}, 32'(ifc.diff), 32'(ed));
    check({tag, "_bout"}, 32'(ifc.bout), 32'(eb));
`ifdef SUB16_OVF_EN
    check({tag, "_ovf"}, 32'(ifc.ovf), 32'(eo));
`else
    if (eo !== eo) $display("unreachable");
`endif
  endtask

  task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input logic [15:0] ed, input logic eb,
                         input logic eo);
    start_op(a, b, bi, 1'b1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check_result(tag, ed, eb, eo);
    @(posedge clk);
    #1;
    check({tag, "_handoff_ov"}, 32'(ifc.out_valid), 32'd0);
    check({tag, "_handoff_ir"}, 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.bin       = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    full_op("t1", 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    full_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    full_op("t3", 16'h4321, 16'h1234, 1'b1, 16'h30EC, 1'b0, 1'b0);
    full_op("t4a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    full_op("t4b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    full_op("bnd1", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    full_op("bnd2", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    full_op("bnd3", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: result must stay frozen and new operands ignored.
    start_op(16'h5000, 16'h0123, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd4);
    check_result("bp", 16'h4EDD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.a        = 16'h1111;
      ifc.b        = 16'h2222;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check_result("bp_hold", 16'h4EDD, 1'b0, 1'b0);
    end
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", 32'(ifc.out_valid), 32'd0);
    check("bp_release_ir", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(ifc.in_ready), 32'd1);

    // Reset in the middle of RUN aborts the operation.
    start_op(16'hABCD, 16'h1234, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_diff", 32'(ifc.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_ov", 32'(ifc.out_valid), 32'd0);
    end
    full_op("after_rst", 16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
